// File: rtl/config_table_streamer.sv
// Configuration table streamer: holds DEPTH words and sends them as an addressed valid/ready sweep.
// Optional checksum beat: define CONFIG_TABLE_STREAMER_CHECKSUM_EN.
module config_table_streamer #(
    parameter int               WIDTH         = 10,
    parameter int               DEPTH         = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
    localparam int              ADDR_WIDTH    = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_last
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state, w_state_next;
    logic                  r_valid, w_valid_next;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_next;
    logic [WIDTH-1:0]      r_data,  w_data_next;
    logic                  r_last,  w_last_next;
    logic [WIDTH-1:0]      r_table [DEPTH];
`ifdef CONFIG_TABLE_STREAMER_CHECKSUM_EN
    logic [WIDTH-1:0]      r_csum,      w_csum_next;
    logic                  r_csum_beat, w_csum_beat_next;
`endif

    logic                  w_wr_ok;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_ld_idx;
    logic [WIDTH-1:0]      w_ld_data;

    assign w_wr_ok  = i_wr_en && (32'(i_wr_addr) < DEPTH);
    assign w_accept = r_valid && i_ready;
    assign w_ld_idx = (r_state == S_IDLE) ? '0 : r_addr + ADDR_WIDTH'(1);
    // A write landing on the entry being loaded this cycle wins over the stored value.
    assign w_ld_data = (w_wr_ok && (i_wr_addr == w_ld_idx)) ? i_wr_data : r_table[w_ld_idx];

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= DEFAULT_VALUE;
            end
        end else if (w_wr_ok) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_valid     <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_last      <= 1'b0;
`ifdef CONFIG_TABLE_STREAMER_CHECKSUM_EN
            r_csum      <= '0;
            r_csum_beat <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_valid     <= w_valid_next;
            r_addr      <= w_addr_next;
            r_data      <= w_data_next;
            r_last      <= w_last_next;
`ifdef CONFIG_TABLE_STREAMER_CHECKSUM_EN
            r_csum      <= w_csum_next;
            r_csum_beat <= w_csum_beat_next;
`endif
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_valid_next     = r_valid;
        w_addr_next      = r_addr;
        w_data_next      = r_data;
        w_last_next      = r_last;
`ifdef CONFIG_TABLE_STREAMER_CHECKSUM_EN
        w_csum_next      = r_csum;
        w_csum_beat_next = r_csum_beat;
`endif
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_SEND;
                    w_valid_next = 1'b1;
                    w_addr_next  = '0;
                    w_data_next  = w_ld_data;
                    w_last_next  = 1'b0;
`ifdef CONFIG_TABLE_STREAMER_CHECKSUM_EN
                    w_csum_next      = '0;
                    w_csum_beat_next = 1'b0;
`endif
                end
            end
            S_SEND: begin
                if (w_accept) begin
`ifdef CONFIG_TABLE_STREAMER_CHECKSUM_EN
                    w_csum_next = r_csum ^ r_data;
                    if (r_csum_beat) begin
                        w_state_next     = S_DONE;
                        w_valid_next     = 1'b0;
                        w_last_next      = 1'b0;
                        w_csum_beat_next = 1'b0;
                    end else if (r_addr == LAST_IDX) begin
                        // Trailing checksum beat reuses address 0 and carries the sweep XOR.
                        w_addr_next      = '0;
                        w_data_next      = r_csum ^ r_data;
                        w_last_next      = 1'b1;
                        w_csum_beat_next = 1'b1;
                    end else begin
                        w_addr_next = w_ld_idx;
                        w_data_next = w_ld_data;
                        w_last_next = 1'b0;
                    end
`else
                    if (r_addr == LAST_IDX) begin
                        w_state_next = S_DONE;
                        w_valid_next = 1'b0;
                        w_last_next  = 1'b0;
                    end else begin
                        w_addr_next = w_ld_idx;
                        w_data_next = w_ld_data;
                        w_last_next = (w_ld_idx == LAST_IDX);
                    end
`endif
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    assign o_busy  = (r_state == S_SEND);
    assign o_done  = (r_state == S_DONE);
    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: tb/tb_config_table_streamer.sv
// Self-checking bench for config_table_streamer: directed sweeps plus random traffic
// compared cycle by cycle against a sweep-level reference model.
module tb_config_table_streamer;

    localparam int WIDTH = 10;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef CONFIG_TABLE_STREAMER_CHECKSUM_EN
    localparam int LAST_BEAT = DEPTH;
`else
    localparam int LAST_BEAT = DEPTH - 1;
`endif

    logic             clk = 1'b0;
    logic             rst_n, start, ready, wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             busy, done, valid, last;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;

    always #5 clk = ~clk;

    config_table_streamer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEFAULT_VALUE('0)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .o_busy(busy), .o_done(done),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .o_valid(valid), .i_ready(ready), .o_addr(addr), .o_data(data), .o_last(last)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a sweep is a list of beats; each beat's value is the table content
    // at the moment it is presented, held until the consumer accepts it.
    bit               m_busy, m_done;
    int               m_beat;
    logic [WIDTH-1:0] m_data, m_xor;
    logic [WIDTH-1:0] m_table [DEPTH];

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_beat = 0; m_data = '0; m_xor = '0;
        for (int i = 0; i < DEPTH; i++) m_table[i] = '0;
    endtask

    task automatic step(input bit r, input bit s, input bit rd, input bit we,
                        input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd);
        check("valid", valid, m_busy);
        check("busy", busy, m_busy);
        check("done", done, m_done);
        if (m_busy) begin
            check("addr", addr, (m_beat == DEPTH) ? 0 : m_beat);
            check("data", data, m_data);
            check("last", last, (m_beat == LAST_BEAT) ? 1 : 0);
        end else begin
            check("last_idle", last, 0);
        end
        rst_n = r; start = s; ready = rd; wr_en = we; wr_addr = wa; wr_data = wd;
        if (!r) begin
            model_reset();
        end else begin
            if (we && (int'(wa) < DEPTH)) m_table[wa] = wd;
            if (m_done) begin
                m_done = 0;
            end else if (m_busy) begin
                if (rd) begin
                    $display("beat addr=%0d data=%03h last=%0d", (m_beat == DEPTH) ? 0 : m_beat,
                             m_data, (m_beat == LAST_BEAT) ? 1 : 0);
                    m_xor ^= m_data;
                    if (m_beat == LAST_BEAT) begin
                        m_busy = 0;
                        m_done = 1;
                    end else begin
                        m_beat++;
                        if (m_beat == DEPTH) m_data = m_xor;
                        else                 m_data = m_table[m_beat];
                    end
                end
            end else if (s) begin
                m_busy = 1; m_beat = 0; m_xor = '0; m_data = m_table[0];
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit s, input bit rd);
        for (int i = 0; i < n; i++) step(1, s, rd, 0, '0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        step(1, 0, 1, 1, a, d);
    endtask

    initial begin
        rst_n = 0; start = 0; ready = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        model_reset();
        @(negedge clk);
        step(0, 0, 0, 0, '0, '0);
        step(1, 0, 0, 0, '0, '0);

        // Plain sweep with full-throughput consumer.
        step(1, 1, 1, 0, '0, '0);
        run(7, 0, 1);

        // Sweep with a toggling ready.
        wr(2, 10'h155);
        wr(3, 10'h2AA);
        step(1, 1, 1, 0, '0, '0);
        for (int i = 0; i < 14; i++) step(1, 0, (i % 3) != 1 && (i % 3) != 2 ? 1'b1 : 1'b0, 0, '0, '0);
        run(3, 0, 1);

        // Writes while beat 1 is stalled: addr 3 visible now, addr 0 next sweep.
        step(1, 1, 1, 0, '0, '0);
        step(1, 0, 1, 0, '0, '0);
        step(1, 0, 0, 1, 2'd3, 10'h3FF);
        step(1, 0, 0, 1, 2'd0, 10'h001);
        run(6, 0, 1);
        step(1, 1, 1, 0, '0, '0);
        run(6, 0, 1);

        // Start held high throughout: one sweep, then a fresh one from the next idle.
        run(14, 1, 1);
        run(4, 0, 1);

        // Reset mid-sweep at beat 2, then confirm table returned to defaults.
        wr(1, 10'h0AB);
        step(1, 1, 1, 0, '0, '0);
        run(2, 0, 1);
        step(0, 0, 1, 0, '0, '0);
        step(1, 0, 1, 0, '0, '0);
        step(1, 1, 1, 0, '0, '0);
        run(6, 0, 1);

        // Checksum reference table.
        wr(0, 10'h001);
        wr(1, 10'h002);
        wr(2, 10'h004);
        wr(3, 10'h3F0);
        step(1, 1, 1, 0, '0, '0);
        run(7, 0, 1);

        // Random traffic, including bypass writes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 AW'($urandom), WIDTH'($urandom));
        end
        run(8, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/config_table_streamer.md
Name: config_table_streamer

Overview:
- Producer side of the constant/configuration path: holds a small table of WIDTH-bit words and transmits it as an addressed valid/ready stream to consumer blocks.
- Consumers otherwise take such values from package constants.
- Table entries reset to DEFAULT_VALUE and can be overwritten through a write port.
- A start pulse triggers one complete in-order sweep of the table.

Parameters:
- WIDTH, 10, data word width.
- DEPTH, 4, number of table entries (>=2).
- ADDR_WIDTH, $clog2(DEPTH), address width; derived, not overridden.
- DEFAULT_VALUE, 0, reset value of every table entry.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  reset, synchronous, active-low.
- i_start  input  1  request one sweep; sampled only in IDLE.
- o_busy  output  1  high in SEND.
- o_done  output  1  one-cycle pulse after the final beat is accepted.
- i_wr_en  input  1  table write strobe.
- i_wr_addr  input  ADDR_WIDTH  write address; out-of-range ignored.
- i_wr_data  input  WIDTH  write data.
- o_valid  output  1  stream beat valid.
- i_ready  input  1  consumer ready.
- o_addr  output  ADDR_WIDTH  table index of current beat.
- o_data  output  WIDTH  data of current beat.
- o_last  output  1  marks final beat of sweep.

Behaviour:
- Reset (i_rst==0 at edge):
  - state=IDLE; all outputs 0.
  - All table entries = DEFAULT_VALUE.
  - Reset mid-sweep aborts the sweep; no o_done.
- FSM IDLE -> SEND -> DONE -> IDLE.
  - IDLE: i_start=1 -> SEND next cycle with o_valid=1, o_addr=0, o_data=table[0]. Latency start->first valid = 1 cycle.
  - SEND, beat accepted when o_valid&&i_ready:
    - Not last: advance to idx+1 next cycle; o_valid stays 1, giving back-to-back beats at full throughput.
    - Last (idx==DEPTH-1): go to DONE; o_valid=0.
  - DONE: o_done=1 for exactly one cycle, then IDLE. i_start in DONE is ignored.
- i_start while in SEND or DONE is ignored; no queuing.
- Stream rules:
  - While o_valid&&!i_ready, o_addr/o_data/o_last hold stable.
  - o_valid never drops without acceptance.
  - o_last = o_valid && (o_addr==DEPTH-1).
- Writes are accepted in any state.
  - Take effect in table next cycle.
  - Do not alter an already-presented beat.
  - Write to the entry being loaded into the output register in the same cycle: the new i_wr_data is bypassed onto o_data.
  - Write to an entry not yet sent in this sweep is visible in this sweep.
  - Write to an already-sent entry is visible in the next sweep only.
- o_addr wraps to 0 only by a new sweep; no modulo overflow inside a sweep.

Optional Feature:
- Macro CONFIG_TABLE_STREAMER_CHECKSUM_EN.
- Defined:
  - After entry DEPTH-1, one extra beat with o_addr=0 and o_data = XOR of all WIDTH-bit data words sent in this sweep.
  - o_last moves to the checksum beat only.
  - o_done follows checksum acceptance.
- Undefined: no extra beat; behaviour as above.

Test Plan:
- Reset, then i_start=1 for one cycle with i_ready=1 -> beats (0,0),(1,0),(2,0),(3,0) on consecutive cycles; o_last on addr 3; o_done one cycle after; o_busy high 4 cycles.
- Write table[2]=10'h155, table[3]=10'h2AA, sweep with i_ready toggled 1,0,0,1,... -> data 0,0,0x155,0x2AA in order; o_data/o_addr stable during every stall cycle.
- During sweep, with beat 1 held by i_ready=0, write table[3]=10'h3FF and table[0]=10'h001 -> this sweep sends 0x3FF at addr 3 and 0 at addr 0; next sweep sends 0x001 at addr 0.
- Assert i_start repeatedly during SEND and DONE -> exactly one sweep, one o_done pulse; a start in the following IDLE starts a new sweep.
- Drive i_rst=0 at beat 2 -> next cycle o_valid=0, o_busy=0, table all DEFAULT_VALUE, no o_done.
- With CONFIG_TABLE_STREAMER_CHECKSUM_EN and table {0x001,0x002,0x004,0x3F0} -> 5 beats; final o_data=0x3F7, o_last only on beat 5.
